// File: rtl/product_acc_pkg.sv
// Shared definitions for the product accumulator: FSM encoding, count width
// and the saturating beat-count helper.
package product_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    localparam int CNT_W = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (c == {CNT_W{1'b1}}) begin
            r = c;
        end else begin
            r = c + CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/product_accumulator_adder.sv
// ACC_W-bit unsigned adder returning the truncated sum and the carry-out.
module acc_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a group of unsigned products, then holds the group sum, sticky
// overflow flag and saturating beat count until downstream takes it.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int ACC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [M+N-1:0]     in_product,
    input  logic               in_last,
    input  logic               clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic               out_ovf,
    output logic [CNT_W-1:0]   out_cnt
);

    if (ACC_W < M + N) begin : g_width_check
        $error("product_accumulator: ACC_W must be >= M+N");
    end

    acc_state_e         state_r, state_nxt_s;
    logic [ACC_W-1:0]   acc_r, acc_nxt_s;
    logic               ovf_r, ovf_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [ACC_W-1:0]   sum_s;
    logic               cout_s;
    logic               accept_s;

    acc_adder #(.W(ACC_W)) u_adder (
        .a    (acc_r),
        .b    (ACC_W'(in_product)),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Handshake outputs depend only on state and clr so upstream sees no
    // combinational path from its own valid.
    always_comb begin
        in_ready  = (state_r == ACCUM) && !clr;
        out_valid = (state_r == HOLD);
        accept_s  = in_valid && in_ready;
    end

    // Next-state and datapath update for the ACCUM/HOLD machine.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        ovf_nxt_s   = ovf_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ACCUM: begin
                if (clr) begin
                    acc_nxt_s = '0;
                    ovf_nxt_s = 1'b0;
                    cnt_nxt_s = '0;
                end else if (accept_s) begin
                    acc_nxt_s = sum_s;
                    ovf_nxt_s = ovf_r | cout_s;
                    cnt_nxt_s = sat_inc(cnt_r);
                    if (in_last) begin
                        state_nxt_s = HOLD;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            HOLD: begin
                // clr is deliberately ignored here so a held result survives.
                if (out_ready) begin
                    state_nxt_s = ACCUM;
                    acc_nxt_s   = '0;
                    ovf_nxt_s   = 1'b0;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = ACCUM;
                acc_nxt_s   = '0;
                ovf_nxt_s   = 1'b0;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // All state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ACCUM;
            acc_r   <= '0;
            ovf_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            ovf_r   <= ovf_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign out_sum = acc_r;
    assign out_ovf = ovf_r;
    assign out_cnt = cnt_r;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator (M=4, N=4, ACC_W=10): expected
// group results are queued by the stimulus and popped by a result monitor.
module tb_product_accumulator;

    localparam int M     = 4;
    localparam int N     = 4;
    localparam int ACC_W = 10;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [M+N-1:0]    in_product;
    logic              in_last;
    logic              clr;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic [7:0]        out_cnt;

    typedef struct {
        int sum;
        int ovf;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    product_accumulator #(.M(M), .N(N), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_last    (in_last),
        .clr        (clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_ovf    (out_ovf),
        .out_cnt    (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Result monitor: a result is consumed on the edge following a negedge
    // where both out_valid and out_ready are high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_sum", int'(out_sum), e.sum);
                chk("res_ovf", int'(out_ovf), e.ovf);
                chk("res_cnt", int'(out_cnt), e.cnt);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one beat and returns (at posedge+1) once it has been accepted.
    task automatic send_beat(input int p, input bit last);
        int guard;
        in_valid   = 1'b1;
        in_product = (M+N)'(p);
        in_last    = last;
        guard      = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) chk("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Waits for out_valid, holds off a few cycles, then takes the result.
    task automatic take_result(input int delay);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!out_valid) chk("result_timeout", 0, 1);
        @(posedge clk);
        #1;
        cyc(delay);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic push_exp(input int s, input int o, input int c);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        e.cnt = c;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_product = '0;
        in_last    = 1'b0;
        clr        = 1'b0;
        out_ready  = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state.
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sum", int'(out_sum), 0);
        chk("rst_ovf", int'(out_ovf), 0);
        chk("rst_cnt", int'(out_cnt), 0);

        // Four beats of 15*15.
        push_exp(900, 0, 4);
        for (int i = 0; i < 4; i++) send_beat(225, i == 3);
        take_result(1);

        // Five beats of 225 wrap modulo 1024.
        push_exp(101, 1, 5);
        for (int i = 0; i < 5; i++) send_beat(225, i == 4);
        take_result(0);

        // Abort a partial group with clr, even while a beat is offered.
        send_beat(10, 1'b0);
        send_beat(20, 1'b0);
        chk("run_sum", int'(out_sum), 30);
        chk("run_cnt", int'(out_cnt), 2);
        chk("run_out_valid", int'(out_valid), 0);
        clr        = 1'b1;
        in_valid   = 1'b1;
        in_product = 8'd99;
        #1;
        chk("clr_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_sum", int'(out_sum), 0);
        chk("clr_cnt", int'(out_cnt), 0);
        push_exp(7, 0, 1);
        send_beat(7, 1'b1);
        take_result(0);

        // HOLD stalls upstream and ignores clr while out_ready stays low.
        push_exp(110, 0, 2);
        send_beat(50, 1'b0);
        send_beat(60, 1'b1);
        in_valid   = 1'b1;
        in_product = 8'd5;
        for (int i = 0; i < 5; i++) begin
            clr = (i == 2);
            @(negedge clk);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_sum", int'(out_sum), 110);
            chk("hold_cnt", int'(out_cnt), 2);
            @(posedge clk);
            #1;
        end
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", int'(out_valid), 0);
        chk("release_sum", int'(out_sum), 0);
        chk("release_in_ready", int'(in_ready), 1);

        // Asynchronous reset mid-group discards the partial sum.
        send_beat(100, 1'b0);
        send_beat(100, 1'b0);
        chk("pre_rst_sum", int'(out_sum), 200);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sum", int'(out_sum), 0);
        chk("async_rst_cnt", int'(out_cnt), 0);
        chk("async_rst_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp(3, 0, 1);
        send_beat(3, 1'b1);
        take_result(2);

        // 300 unit beats under random backpressure: count saturates at 255.
        push_exp(300, 0, 255);
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 2));
            send_beat(1, i == 299);
        end
        take_result($urandom_range(0, 4));

        cyc(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
